// File: rtl/des_key_rotator.sv
// des_key_rotator: sequential DES key-schedule engine streaming rotated C||D
// round values with valid/ready flow control and encrypt/decrypt modes.
module des_key_rotator #(
    parameter int          N         = 28,
    parameter int          ROUNDS    = 16,
    parameter logic [31:0] SHIFT_MAP = 32'h0000_7EFC,
    parameter int          RW        = $clog2(ROUNDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_valid,
    output logic            key_ready,
    input  logic [0:2*N-1]  key_in,
    input  logic            decrypt,
    input  logic            abort,
    output logic            sub_valid,
    input  logic            sub_ready,
    output logic [0:2*N-1]  sub_cd,
    output logic [RW-1:0]   sub_round,
    output logic            sub_last,
    output logic            busy
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state, state_nxt;
    logic           mode, accept, adv, fin, rot_mode;
    logic [RW-1:0]  rot_round;
    logic [1:0]     rot_k;
    logic [0:2*N-1] rot_src, rot_out;

    function automatic logic [0:N-1] rot_half(input logic [0:N-1] h, input logic [1:0] k, input logic r);
        return r ? (h >> k) | (h << (N - int'(k))) : (h << k) | (h >> (N - int'(k)));
    endfunction

    // Decrypt walks the encrypt schedule backwards: round 0 is the unrotated key.
    function automatic logic [1:0] shift_of(input logic [RW-1:0] r, input logic m);
        logic [4:0] e;
        e = m ? 5'(ROUNDS - int'(r)) : 5'(r);
        return (m && r == '0) ? 2'd0 : (SHIFT_MAP[e] ? 2'd2 : 2'd1);
    endfunction

    assign key_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign sub_last  = sub_round == RW'(ROUNDS - 1);

    always_comb begin
        accept    = key_valid && state == IDLE && !abort;
        adv       = state == EMIT && sub_valid && sub_ready && !sub_last && !abort;
        fin       = state == EMIT && sub_valid && sub_ready && sub_last && !abort;
        rot_round = accept ? '0 : sub_round + RW'(1);
        rot_mode  = accept ? decrypt : mode;
        rot_src   = accept ? key_in : sub_cd;
        rot_k     = shift_of(rot_round, rot_mode);
        rot_out   = {rot_half(rot_src[0:N-1], rot_k, rot_mode), rot_half(rot_src[N:2*N-1], rot_k, rot_mode)};
        state_nxt = abort ? IDLE : accept ? EMIT : fin ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_valid <= 1'b0;
            sub_cd    <= '0;
            sub_round <= '0;
            mode      <= 1'b0;
        end else if (abort) begin
            sub_valid <= 1'b0;
            sub_round <= '0;
        end else if (accept) begin
            mode      <= decrypt;
            sub_cd    <= rot_out;
            sub_round <= '0;
            sub_valid <= 1'b1;
        end else if (adv) begin
            sub_cd    <= rot_out;
            sub_round <= rot_round;
        end else if (fin) begin
            sub_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_des_key_rotator.sv
// tb_des_key_rotator: directed checks of the DES key rotator, default and small configs.
module tb_des_key_rotator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid, key_ready, decrypt, abort, sub_valid, sub_ready, sub_last, busy;
    logic [55:0] key_in, sub_cd;
    logic [3:0]  sub_round;
    logic        b_key_valid, b_key_ready, b_sub_valid, b_sub_last, b_busy;
    logic [15:0] b_key_in, b_sub_cd;
    logic [1:0]  b_sub_round;
    int          checks = 0;
    int          errors = 0;

    localparam logic [55:0] KEY = {28'hF0CCAAF, 28'h556678F};
    // FIPS-46 example C||D for encrypt rounds 0..15
    logic [55:0] enc [16] = '{
        56'hE19955F_AACCF1E, 56'hC332ABF_5599E3D, 56'h0CCAAFF_56678F5, 56'h332ABFC_599E3D5,
        56'hCCAAFF0_6678F55, 56'h32ABFC3_99E3D55, 56'hCAAFF0C_678F556, 56'h2ABFC33_9E3D559,
        56'h557F866_3C7AAB3, 56'h55FE199_F1EAACC, 56'h57F8665_C7AAB33, 56'h5FE1995_1EAACCF,
        56'h7F86655_7AAB33C, 56'hFE19955_EAACCF1, 56'hF866557_AAB33C7, 56'hF0CCAAF_556678F};
    logic [15:0] small_exp [4] = '{16'h0306, 16'h0C18, 16'h3060, 16'h60C0};

    always #5 clk = ~clk;

    des_key_rotator dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .decrypt(decrypt), .abort(abort), .sub_valid(sub_valid),
        .sub_ready(sub_ready), .sub_cd(sub_cd), .sub_round(sub_round),
        .sub_last(sub_last), .busy(busy));

    des_key_rotator #(.N(8), .ROUNDS(4), .SHIFT_MAP(32'h6)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_valid(b_key_valid), .key_ready(b_key_ready),
        .key_in(b_key_in), .decrypt(1'b0), .abort(1'b0), .sub_valid(b_sub_valid),
        .sub_ready(1'b1), .sub_cd(b_sub_cd), .sub_round(b_sub_round),
        .sub_last(b_sub_last), .busy(b_busy));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_key(input logic dec, input string tag);
        key_valid = 1'b1;
        key_in    = KEY;
        decrypt   = dec;
        sub_ready = 1'b1;
        step();
        key_valid = 1'b0;
        key_in    = ~KEY;
        decrypt   = ~dec;
        for (int r = 0; r < 16; r++) begin
            chk({tag, " valid"}, 64'(sub_valid), 64'd1);
            chk({tag, " round"}, 64'(sub_round), 64'(r));
            chk({tag, " cd"}, 64'(sub_cd), 64'(dec ? enc[15-r] : enc[r]));
            chk({tag, " last"}, 64'(sub_last), 64'(r == 15));
            chk({tag, " key_ready"}, 64'(key_ready), 64'd0);
            step();
        end
        chk({tag, " end valid"}, 64'(sub_valid), 64'd0);
        chk({tag, " end key_ready"}, 64'(key_ready), 64'd1);
        chk({tag, " end busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int r;
        logic [55:0] held;
        rst_n = 1'b1; key_valid = 1'b0; key_in = '0; decrypt = 1'b0; abort = 1'b0; sub_ready = 1'b0;
        b_key_valid = 1'b0; b_key_in = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst key_ready", 64'(key_ready), 64'd1);
        chk("rst sub_valid", 64'(sub_valid), 64'd0);
        chk("rst sub_cd", 64'(sub_cd), 64'd0);
        chk("rst sub_round", 64'(sub_round), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        run_key(1'b0, "enc");

        // back-pressure: sub_ready random, outputs must hold while stalled
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; sub_ready = 1'b0;
        step();
        key_valid = 1'b0;
        r = 0;
        for (int cyc = 0; cyc < 120 && r < 16; cyc++) begin
            chk("bp round", 64'(sub_round), 64'(r));
            chk("bp cd", 64'(sub_cd), 64'(enc[r]));
            chk("bp valid", 64'(sub_valid), 64'd1);
            chk("bp key_ready", 64'(key_ready), 64'd0);
            sub_ready = 1'($urandom_range(0, 1));
            step();
            if (sub_ready) r++;
        end
        chk("bp all rounds", 64'(r), 64'd16);
        chk("bp end key_ready", 64'(key_ready), 64'd1);
        chk("bp end valid", 64'(sub_valid), 64'd0);

        run_key(1'b1, "dec");

        // abort at round 5 together with a key
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; sub_ready = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (5) step();
        chk("ab round5", 64'(sub_round), 64'd5);
        held = sub_cd;
        chk("ab cd5", 64'(held), 64'(enc[5]));
        abort = 1'b1; key_valid = 1'b1; key_in = 56'h0123456_789ABCD; decrypt = 1'b1;
        step();
        abort = 1'b0; key_valid = 1'b0;
        chk("ab valid", 64'(sub_valid), 64'd0);
        chk("ab key_ready", 64'(key_ready), 64'd1);
        chk("ab round", 64'(sub_round), 64'd0);
        chk("ab cd kept", 64'(sub_cd), 64'(held));
        step();
        chk("ab key not taken", 64'(busy), 64'd0);
        chk("ab still idle valid", 64'(sub_valid), 64'd0);
        run_key(1'b0, "ab restart");

        // asynchronous reset mid-stream at round 9
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; sub_ready = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (9) step();
        chk("rs round9", 64'(sub_round), 64'd9);
        #3 rst_n = 1'b0;
        #1;
        chk("rs valid", 64'(sub_valid), 64'd0);
        chk("rs round", 64'(sub_round), 64'd0);
        chk("rs cd", 64'(sub_cd), 64'd0);
        chk("rs key_ready", 64'(key_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rs post key_ready", 64'(key_ready), 64'd1);
        run_key(1'b0, "rs restart");

        // small configuration: N=8, ROUNDS=4, map 4'b0110
        b_key_valid = 1'b1; b_key_in = 16'h8103;
        step();
        b_key_valid = 1'b0; b_key_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk("n8 valid", 64'(b_sub_valid), 64'd1);
            chk("n8 round", 64'(b_sub_round), 64'(i));
            chk("n8 cd", 64'(b_sub_cd), 64'(small_exp[i]));
            chk("n8 last", 64'(b_sub_last), 64'(i == 3));
            step();
        end
        chk("n8 end valid", 64'(b_sub_valid), 64'd0);
        chk("n8 end key_ready", 64'(b_key_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
